// File: rtl/uart_alu_pkg.sv
// Shared opcodes, ALU operation codes and controller state encoding for the
// UART-ALU packet sequencer.
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'h8A;
    localparam logic [7:0] OP_MUL  = 8'h8B;
    localparam logic [7:0] OP_DIV  = 8'h8C;

    localparam int unsigned HDR_BYTES = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_MUL = 2'd1,
        ALU_DIV = 2'd2
    } alu_op_e;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        ECHO  = 3'd1,
        OPND  = 3'd2,
        EXEC  = 3'd3,
        WAIT  = 3'd4,
        RESP  = 3'd5,
        DRAIN = 3'd6
    } ctrl_state_e;

    function automatic logic is_arith(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic alu_op_e op_to_alu(input logic [7:0] op);
        case (op)
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_ctrl_ser.sv
// 32-bit word to 4-byte LSB-first serialiser with a valid/ready byte output.
module uart_alu_ctrl_ser (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        ready_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        done_o
);

    logic [31:0] shift_q;
    logic [1:0]  cnt_q;
    logic        valid_q;

    // Shift out one byte per accepted handshake; the current byte always sits in the low lane
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= 32'h0000_0000;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= data_i;
            cnt_q   <= 2'd0;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            if (cnt_q == 2'd3) begin
                valid_q <= 1'b0;
            end else begin
                shift_q <= {8'h00, shift_q[31:8]};
                cnt_q   <= cnt_q + 2'd1;
            end
        end
    end

    assign data_o  = shift_q[7:0];
    assign valid_o = valid_q;
    assign done_o  = valid_q && ready_i && (cnt_q == 2'd3);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Packet sequencer between UART RX, the ALU and UART TX.
// Optional inter-byte timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 600000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    input  logic [31:0] alu_res_i,
    input  logic        alu_res_valid_i,
    output logic        busy_o,
    output logic        err_o
);

    ctrl_state_e state_q;
    logic [15:0] byte_cnt_q, len_q;
    logic [7:0]  op_q, len_lo_q, echo_data_q;
    alu_op_e     alu_op_q;
    logic [31:0] acc_q, opnd_q;
    logic        first_q, alu_valid_q, err_q, echo_valid_q, ser_pend_q;

    logic        rx_ready_s, rx_fire_s, last_s, timeout_s;
    logic        ser_load_s, ser_valid_s, ser_done_s;
    logic [7:0]  ser_data_s;
    logic [15:0] len_s, cnt_inc_s;
    logic [31:0] word_s;

    assign rx_fire_s  = rx_valid_i && rx_ready_s;
    assign cnt_inc_s  = byte_cnt_q + 16'd1;
    assign last_s     = (cnt_inc_s == len_q);
    assign len_s      = {rx_data_i, len_lo_q};
    assign word_s     = {rx_data_i, opnd_q[31:8]};
    assign ser_load_s = (state_q == RESP) && ser_pend_q && !echo_valid_q;

    // Receive back-pressure: echo only accepts when the output slot frees this cycle
    always_comb begin
        rx_ready_s = 1'b0;
        case (state_q)
            HDR, OPND, DRAIN: rx_ready_s = 1'b1;
            ECHO:             rx_ready_s = !echo_valid_q || tx_ready_i;
            default:          rx_ready_s = 1'b0;
        endcase
    end

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            to_active_s;

    // Idle watchdog only runs while a packet is partially received
    always_comb begin
        to_active_s = 1'b0;
        case (state_q)
            ECHO, OPND, DRAIN: to_active_s = 1'b1;
            HDR:               to_active_s = (byte_cnt_q != 16'd0);
            default:           to_active_s = 1'b0;
        endcase
    end

    assign timeout_s = to_active_s && !rx_fire_s && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter, cleared by every accepted byte
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (!to_active_s || rx_fire_s || timeout_s) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
    assign timeout_s        = 1'b0;
`endif

    // Packet sequencer: header decode, payload routing, ALU handshake and response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HDR;
            byte_cnt_q   <= 16'd0;
            len_q        <= 16'd0;
            op_q         <= 8'h00;
            len_lo_q     <= 8'h00;
            echo_data_q  <= 8'h00;
            alu_op_q     <= ALU_ADD;
            acc_q        <= 32'h0000_0000;
            opnd_q       <= 32'h0000_0000;
            first_q      <= 1'b0;
            alu_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            echo_valid_q <= 1'b0;
            ser_pend_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (echo_valid_q && tx_ready_i) begin
                echo_valid_q <= 1'b0;
            end
            case (state_q)
                HDR: begin
                    if (timeout_s) begin
                        err_q      <= 1'b1;
                        byte_cnt_q <= 16'd0;
                    end else if (rx_fire_s) begin
                        byte_cnt_q <= cnt_inc_s;
                        case (byte_cnt_q[1:0])
                            2'd0: op_q     <= rx_data_i;
                            2'd2: len_lo_q <= rx_data_i;
                            2'd3: begin
                                len_q    <= len_s;
                                alu_op_q <= op_to_alu(op_q);
                                first_q  <= 1'b1;
                                if (op_q == OP_ECHO && len_s == 16'd4) begin
                                    byte_cnt_q <= 16'd0;
                                end else if (op_q == OP_ECHO && len_s > 16'd4) begin
                                    state_q <= ECHO;
                                end else if (is_arith(op_q) && len_s >= 16'd8 && len_s[1:0] == 2'd0) begin
                                    state_q <= OPND;
                                end else begin
                                    err_q <= 1'b1;
                                    if (len_s > 16'd4) begin
                                        state_q <= DRAIN;
                                    end else begin
                                        byte_cnt_q <= 16'd0;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ECHO: begin
                    if (timeout_s) begin
                        err_q      <= 1'b1;
                        state_q    <= HDR;
                        byte_cnt_q <= 16'd0;
                    end else if (rx_fire_s) begin
                        echo_data_q  <= rx_data_i;
                        echo_valid_q <= 1'b1;
                        byte_cnt_q   <= last_s ? 16'd0 : cnt_inc_s;
                        if (last_s) begin
                            state_q <= HDR;
                        end
                    end
                end
                OPND: begin
                    if (timeout_s) begin
                        err_q      <= 1'b1;
                        state_q    <= HDR;
                        byte_cnt_q <= 16'd0;
                    end else if (rx_fire_s) begin
                        byte_cnt_q <= cnt_inc_s;
                        opnd_q     <= word_s;
                        if (byte_cnt_q[1:0] == 2'd3) begin
                            if (first_q) begin
                                acc_q      <= word_s;
                                first_q    <= 1'b0;
                                ser_pend_q <= last_s;
                                if (last_s) begin
                                    state_q <= RESP;
                                end
                            end else begin
                                alu_valid_q <= 1'b1;
                                state_q     <= EXEC;
                            end
                        end
                    end
                end
                EXEC: begin
                    if (alu_ready_i) begin
                        alu_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (alu_res_valid_i) begin
                        acc_q <= alu_res_i;
                        if (byte_cnt_q == len_q) begin
                            state_q    <= RESP;
                            ser_pend_q <= 1'b1;
                        end else begin
                            state_q <= OPND;
                        end
                    end
                end
                RESP: begin
                    if (ser_load_s) begin
                        ser_pend_q <= 1'b0;
                    end
                    if (ser_done_s) begin
                        state_q    <= HDR;
                        byte_cnt_q <= 16'd0;
                    end
                end
                DRAIN: begin
                    if (timeout_s) begin
                        err_q      <= 1'b1;
                        state_q    <= HDR;
                        byte_cnt_q <= 16'd0;
                    end else if (rx_fire_s) begin
                        byte_cnt_q <= last_s ? 16'd0 : cnt_inc_s;
                        if (last_s) begin
                            state_q <= HDR;
                        end
                    end
                end
                default: begin
                    state_q    <= HDR;
                    byte_cnt_q <= 16'd0;
                end
            endcase
        end
    end

    uart_alu_ctrl_ser u_ser (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (ser_load_s),
        .data_i  (acc_q),
        .ready_i (tx_ready_i),
        .data_o  (ser_data_s),
        .valid_o (ser_valid_s),
        .done_o  (ser_done_s)
    );

    assign rx_ready_o  = rx_ready_s;
    assign tx_data_o   = echo_valid_q ? echo_data_q : ser_data_s;
    assign tx_valid_o  = echo_valid_q || ser_valid_s;
    assign alu_op_o    = alu_op_q;
    assign alu_a_o     = acc_q;
    assign alu_b_o     = opnd_q;
    assign alu_valid_o = alu_valid_q;
    assign busy_o      = (state_q != HDR) || (byte_cnt_q != 16'd0);
    assign err_o       = err_q;

endmodule
